fault_event_logger: RTL and testbench

- Result-side counterpart to the operand-driving stimulus path of `fault_checker`.
- Samples one `fault_checker` result per valid cycle and keeps saturating statistics: total operations, faults, dropped records.
- Buffers each faulting result as a record in a FIFO and streams records out over a valid/ready interface to a trace or debug sink.
- Raises a sticky escalation flag when faults repeat back-to-back, so the precision controller can lock full-width mode.

---
 rtl/fault_event_logger.sv | 150 +++++++++++++++
 tb/tb_fault_event_logger.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fault_event_logger.sv
// Result-side logger for fault_checker: saturating statistics, a FIFO of faulting records
// streamed over valid/ready, and a sticky escalation flag for repeated back-to-back faults.
module fault_event_logger #(
    parameter int unsigned FULL_NBITS  = 32,
    parameter int unsigned TRUNC_NBITS = 16,
    parameter int unsigned SCALE_W     = 7,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned FAULT_RUN   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic                     in_fault,
    input  logic                     in_mode,
    input  logic [FULL_NBITS-1:0]    in_true_sum,
    input  logic [TRUNC_NBITS-1:0]   in_used_sum,
    input  logic [SCALE_W-1:0]       in_true_scale,
    input  logic [SCALE_W-1:0]       in_used_scale,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic [CNT_W-1:0]         rec_seq,
    output logic                     rec_mode,
    output logic [FULL_NBITS-1:0]    rec_true_sum,
    output logic [TRUNC_NBITS-1:0]   rec_used_sum,
    output logic [SCALE_W:0]         rec_scale_diff,
    output logic [CNT_W-1:0]         total_cnt,
    output logic [CNT_W-1:0]         fault_cnt,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     escalate
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [7:0]       RUN_LIM  = 8'(FAULT_RUN);

    typedef enum logic [1:0] {StNormal, StArmed, StLocked} esc_state_e;

    logic [CNT_W-1:0]       seq_mem   [DEPTH];
    logic                   mode_mem  [DEPTH];
    logic [FULL_NBITS-1:0]  true_mem  [DEPTH];
    logic [TRUNC_NBITS-1:0] used_mem  [DEPTH];
    logic [SCALE_W:0]       diff_mem  [DEPTH];

    logic [AW-1:0] wr_ptr, rd_ptr;
    esc_state_e    state;
    logic [7:0]    run;

    logic             sample_fault, pop, full, push_ok, drop;
    logic [SCALE_W:0] scale_diff;

    always_comb begin
        sample_fault = in_valid & in_fault;
        pop          = rec_valid & rec_ready;
        full         = (fifo_level == LVL_FULL);
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_ok      = sample_fault & (~full | pop);
        drop         = sample_fault & full & ~pop;
        scale_diff   = {in_true_scale[SCALE_W-1], in_true_scale}
                     - {in_used_scale[SCALE_W-1], in_used_scale};
    end

    assign rec_valid      = (fifo_level != '0);
    assign rec_seq        = rec_valid ? seq_mem[rd_ptr]  : '0;
    assign rec_mode       = rec_valid ? mode_mem[rd_ptr] : 1'b0;
    assign rec_true_sum   = rec_valid ? true_mem[rd_ptr] : '0;
    assign rec_used_sum   = rec_valid ? used_mem[rd_ptr] : '0;
    assign rec_scale_diff = rec_valid ? diff_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            seq_mem[wr_ptr]  <= total_cnt;
            mode_mem[wr_ptr] <= in_mode;
            true_mem[wr_ptr] <= in_true_sum;
            used_mem[wr_ptr] <= in_used_sum;
            diff_mem[wr_ptr] <= scale_diff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_cnt  <= '0;
            fault_cnt  <= '0;
            drop_cnt   <= '0;
            fifo_level <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else if (clear) begin
            total_cnt  <= '0;
            fault_cnt  <= '0;
            drop_cnt   <= '0;
            fifo_level <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            if (in_valid && total_cnt != '1) total_cnt <= total_cnt + CNT_ONE;
            if (sample_fault && fault_cnt != '1) fault_cnt <= fault_cnt + CNT_ONE;
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_ONE;
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            fifo_level <= fifo_level + LW'(push_ok) - LW'(pop);
        end
    end

    // Idle cycles neither advance nor break a fault run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StNormal;
            run      <= '0;
            escalate <= 1'b0;
        end else if (clear) begin
            state    <= StNormal;
            run      <= '0;
            escalate <= 1'b0;
        end else if (in_valid) begin
            unique case (state)
                StNormal: begin
                    if (in_fault) begin
                        run <= 8'd1;
                        if (RUN_LIM == 8'd1) begin
                            state    <= StLocked;
                            escalate <= 1'b1;
                        end else begin
                            state <= StArmed;
                        end
                    end
                end
                StArmed: begin
                    if (in_fault) begin
                        run <= run + 8'd1;
                        if (run + 8'd1 == RUN_LIM) begin
                            state    <= StLocked;
                            escalate <= 1'b1;
                        end
                    end else begin
                        run   <= '0;
                        state <= StNormal;
                    end
                end
                StLocked: escalate <= 1'b1;
                default: state <= StNormal;
            endcase
        end
    end

endmodule

// File: tb/tb_fault_event_logger.sv
// Self-checking bench for fault_event_logger: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_fault_event_logger;
    localparam int DEPTH = 8;
    localparam int FAULT_RUN = 4;
    localparam int CMAX = 65535;

    logic        clk = 1'b0;
    logic        rst_n, clear, in_valid, in_fault, in_mode, rec_ready;
    logic [31:0] in_true_sum;
    logic [15:0] in_used_sum;
    logic [6:0]  in_true_scale, in_used_scale;
    logic        rec_valid, rec_mode, escalate;
    logic [15:0] rec_seq, rec_used_sum, total_cnt, fault_cnt, drop_cnt;
    logic [31:0] rec_true_sum;
    logic [7:0]  rec_scale_diff;
    logic [3:0]  fifo_level;

    fault_event_logger dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_fault(in_fault), .in_mode(in_mode),
        .in_true_sum(in_true_sum), .in_used_sum(in_used_sum),
        .in_true_scale(in_true_scale), .in_used_scale(in_used_scale),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_seq(rec_seq),
        .rec_mode(rec_mode), .rec_true_sum(rec_true_sum), .rec_used_sum(rec_used_sum),
        .rec_scale_diff(rec_scale_diff), .total_cnt(total_cnt), .fault_cnt(fault_cnt),
        .drop_cnt(drop_cnt), .fifo_level(fifo_level), .escalate(escalate)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] seq;
        logic        mode;
        logic [31:0] ts;
        logic [15:0] us;
        logic [7:0]  sd;
    } rec_t;

    rec_t q[$];
    int   m_total, m_fault, m_drop, m_run;
    bit   m_esc;
    int   checks = 0;
    int   failures = 0;

    task automatic model_reset();
        q.delete();
        m_total = 0; m_fault = 0; m_drop = 0; m_run = 0; m_esc = 0;
    endtask

    task automatic idle_inputs();
        clear = 0; in_valid = 0; in_fault = 0; in_mode = 0;
        in_true_sum = '0; in_used_sum = '0; in_true_scale = '0; in_used_scale = '0;
    endtask

    task automatic rand_data();
        in_mode = 1'($urandom); in_true_sum = $urandom; in_used_sum = 16'($urandom);
        in_true_scale = 7'($urandom); in_used_scale = 7'($urandom);
    endtask

    // Advance one clock, updating the reference model from the inputs seen at the edge.
    task automatic cycle();
        bit   pop, push;
        rec_t r;
        int   d;
        if (clear) begin
            model_reset();
        end else begin
            pop  = (q.size() > 0) && rec_ready;
            push = in_valid && in_fault;
            if (push) begin
                d = int'($signed(in_true_scale)) - int'($signed(in_used_scale));
                r.seq = 16'(m_total); r.mode = in_mode; r.ts = in_true_sum;
                r.us = in_used_sum; r.sd = d[7:0];
            end
            if (in_valid) begin
                if (m_total < CMAX) m_total++;
                if (in_fault) begin
                    if (m_fault < CMAX) m_fault++;
                    m_run++;
                end else begin
                    m_run = 0;
                end
                if (m_run >= FAULT_RUN) m_esc = 1;
            end
            if (pop) void'(q.pop_front());
            if (push) begin
                if (q.size() == DEPTH) begin
                    if (m_drop < CMAX) m_drop++;
                end else begin
                    q.push_back(r);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        idle_inputs();
        clear = 1;
        cycle();
        clear = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rec_ready = 0;
        rst_n = 0;
        model_reset();
        @(posedge clk); #1;
        rst_n = 1;
        repeat (5) cycle();
        checks++;
        if ({total_cnt, fault_cnt, drop_cnt} !== 48'd0 || fifo_level !== 4'd0) begin
            failures++;
            $display("FAIL reset_counters got tot=%0d flt=%0d drp=%0d lvl=%0d exp all 0",
                     total_cnt, fault_cnt, drop_cnt, fifo_level);
        end
        checks++;
        if (rec_valid !== 1'b0 || escalate !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got rec_valid=%b escalate=%b exp 0 0", rec_valid, escalate);
        end
    endtask

    task automatic test_sample();
        rec_ready = 0;
        in_valid = 1; in_fault = 0;
        cycle();
        checks++;
        if (rec_valid !== 1'b0) begin
            failures++;
            $display("FAIL nonfault_no_record got rec_valid=%b exp 0", rec_valid);
        end
        in_fault = 1; in_mode = 1; in_true_sum = 32'h3F800000; in_used_sum = 16'h3F80;
        in_true_scale = 7'h05; in_used_scale = 7'h7E;
        cycle();
        idle_inputs();
        checks++;
        if (total_cnt !== 16'd2 || fault_cnt !== 16'd1) begin
            failures++;
            $display("FAIL sample_counts got tot=%0d flt=%0d exp 2 1", total_cnt, fault_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rec_valid !== 1'b1 || rec_seq !== 16'd1 || rec_scale_diff !== 8'h07 ||
                rec_mode !== 1'b1 || rec_true_sum !== 32'h3F800000 || rec_used_sum !== 16'h3F80)
            begin
                failures++;
                $display("FAIL sample_record_hold[%0d] got v=%b seq=%0d sd=%h m=%b ts=%h us=%h exp 1 1 07 1 3f800000 3f80",
                         i, rec_valid, rec_seq, rec_scale_diff, rec_mode, rec_true_sum,
                         rec_used_sum);
            end
            cycle();
        end
        rec_ready = 1;
        cycle();
        rec_ready = 0;
        checks++;
        if (rec_valid !== 1'b0) begin
            failures++;
            $display("FAIL sample_pop got rec_valid=%b exp 0", rec_valid);
        end
    endtask

    task automatic test_overflow();
        do_clear();
        rec_ready = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1; in_fault = 1; rand_data();
            cycle();
        end
        idle_inputs();
        checks++;
        if (fifo_level !== 4'd8 || drop_cnt !== 16'd2 || rec_seq !== 16'd0) begin
            failures++;
            $display("FAIL overflow got lvl=%0d drop=%0d head=%0d exp 8 2 0",
                     fifo_level, drop_cnt, rec_seq);
        end
        rec_ready = 1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rec_valid !== 1'b1 || rec_seq !== 16'(i)) begin
                failures++;
                $display("FAIL drain_order got v=%b seq=%0d exp 1 %0d", rec_valid, rec_seq, i);
            end
            cycle();
        end
        rec_ready = 0;
        checks++;
        if (rec_valid !== 1'b0 || fifo_level !== 4'd0) begin
            failures++;
            $display("FAIL drain_empty got v=%b lvl=%0d exp 0 0", rec_valid, fifo_level);
        end
    endtask

    task automatic test_full_push_pop();
        do_clear();
        rec_ready = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1; in_fault = 1; rand_data();
            cycle();
        end
        rec_ready = 1; rand_data();
        cycle();
        idle_inputs();
        checks++;
        if (fifo_level !== 4'd8 || drop_cnt !== 16'd0 || rec_seq !== 16'd1) begin
            failures++;
            $display("FAIL full_push_pop got lvl=%0d drop=%0d head=%0d exp 8 0 1",
                     fifo_level, drop_cnt, rec_seq);
        end
        repeat (7) cycle();
        rec_ready = 0;
        checks++;
        if (rec_valid !== 1'b1 || rec_seq !== 16'd8 || fifo_level !== 4'd1) begin
            failures++;
            $display("FAIL full_tail got v=%b seq=%0d lvl=%0d exp 1 8 1",
                     rec_valid, rec_seq, fifo_level);
        end
    endtask

    task automatic test_escalation();
        bit pat [4] = '{1, 1, 1, 0};
        do_clear();
        rec_ready = 1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_fault = pat[i];
            cycle();
            checks++;
            if (escalate !== 1'b0) begin
                failures++;
                $display("FAIL esc_broken_run[%0d] got %b exp 0", i, escalate);
            end
        end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_fault = 1;
            cycle();
            checks++;
            if (escalate !== (i == 3)) begin
                failures++;
                $display("FAIL esc_run[%0d] got %b exp %0d", i, escalate, i == 3);
            end
            idle_inputs();
            repeat (2) cycle();
        end
        in_valid = 1; in_fault = 0;
        cycle();
        idle_inputs();
        checks++;
        if (escalate !== 1'b1) begin
            failures++;
            $display("FAIL esc_sticky got %b exp 1", escalate);
        end
        do_clear();
        checks++;
        if (escalate !== 1'b0) begin
            failures++;
            $display("FAIL esc_clear got %b exp 0", escalate);
        end
    endtask

    task automatic test_async_reset();
        do_clear();
        rec_ready = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_fault = 1; rand_data();
            cycle();
        end
        idle_inputs();
        checks++;
        if (fifo_level !== 4'd5 || escalate !== 1'b1) begin
            failures++;
            $display("FAIL async_pre got lvl=%0d esc=%b exp 5 1", fifo_level, escalate);
        end
        #2 rst_n = 0;
        #1;
        model_reset();
        checks++;
        if (fifo_level !== 4'd0 || rec_valid !== 1'b0 || escalate !== 1'b0 ||
            total_cnt !== 16'd0 || rec_seq !== 16'd0) begin
            failures++;
            $display("FAIL async_reset got lvl=%0d v=%b esc=%b tot=%0d seq=%0d exp all 0",
                     fifo_level, rec_valid, escalate, total_cnt, rec_seq);
        end
        rst_n = 1;
        @(posedge clk); #1;
        in_valid = 1; in_fault = 1; rand_data();
        cycle();
        idle_inputs();
        checks++;
        if (rec_valid !== 1'b1 || rec_seq !== 16'd0) begin
            failures++;
            $display("FAIL async_first_seq got v=%b seq=%0d exp 1 0", rec_valid, rec_seq);
        end
    endtask

    task automatic test_random();
        bit bad;
        do_clear();
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(9) < 7);
            in_fault  = ($urandom_range(9) < 5);
            rec_ready = ($urandom_range(9) < 4);
            clear     = ($urandom_range(99) < 2);
            rand_data();
            cycle();
            bad = (total_cnt !== 16'(m_total)) || (fault_cnt !== 16'(m_fault)) ||
                  (drop_cnt !== 16'(m_drop)) || (fifo_level !== 4'(q.size())) ||
                  (rec_valid !== (q.size() > 0)) || (escalate !== m_esc);
            if (!bad && q.size() > 0)
                bad = (rec_seq !== q[0].seq) || (rec_mode !== q[0].mode) ||
                      (rec_true_sum !== q[0].ts) || (rec_used_sum !== q[0].us) ||
                      (rec_scale_diff !== q[0].sd);
            checks++;
            if (bad) begin
                failures++;
                $display("FAIL random[%0d] got tot=%0d flt=%0d drp=%0d lvl=%0d esc=%b seq=%0d exp tot=%0d flt=%0d drp=%0d lvl=%0d esc=%b",
                         n, total_cnt, fault_cnt, drop_cnt, fifo_level, escalate, rec_seq,
                         m_total, m_fault, m_drop, q.size(), m_esc);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_sample();
        test_overflow();
        test_full_push_pop();
        test_escalation();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
